// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/ME shared memory bus arbiter with fetch anti-starvation streak limit
// Optional bus-wait timeout abort is compiled in when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_type,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [2:0]        bus_type,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              stall,
  output logic              bus_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_DM_BUSY = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [2:0] TYPE_WORD  = 3'b010;

  logic [1:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]        bus_type_q, bus_type_d;

  logic busy;
  logic tmo_fire;
  logic xfer_end;
  logic dm_wins;

  assign busy = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] wait_q, wait_d;

  assign tmo_fire = busy && !bus_ready && (wait_q == TMO_LIMIT);

  // Held at zero while idle so every BUSY entry starts counting from 0.
  always_comb begin
    wait_d = wait_q;
    if (!busy) begin
      wait_d = '0;
    end else if (!bus_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic [7:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 8'(TIMEOUT_CYC);
  assign tmo_fire       = 1'b0;
`endif

  assign xfer_end = bus_ready || tmo_fire;

  // Data normally wins; once the streak limit is hit a waiting fetch gets the bus.
  assign dm_wins = dm_req && (!if_req || (streak_q < STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_type_d  = bus_type_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_wins) begin
          state_d     = ST_DM_BUSY;
          bus_we_d    = dm_we;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          bus_type_d  = dm_type;
          if (if_req) begin
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d     = ST_IF_BUSY;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_type_d  = TYPE_WORD;
          streak_d    = '0;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (xfer_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_type_q  <= bus_type_d;
    end
  end

  assign bus_req   = busy;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_type  = bus_type_q;
  assign bus_err   = tmo_fire;

  assign if_done  = (state_q == ST_IF_BUSY) && xfer_end;
  assign dm_done  = (state_q == ST_DM_BUSY) && xfer_end;
  assign if_rdata = tmo_fire ? '0 : bus_rdata;
  assign dm_rdata = tmo_fire ? '0 : bus_rdata;

  assign stall = (if_req && !if_done) || (dm_req && !dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
// Timeout checks are compiled in when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, dm_req, dm_we, dm_done;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_type, bus_type;
  logic        bus_req, bus_we, bus_ready, stall, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_type(bus_type), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), what it must show, and the data streak.
  int          owner = 0;
  int          streak = 0;
  int          wait_cnt = 0;
  int          lat = 0;
  int          lat_fix = 0;
  bit          ready_never = 0;
  bit          auto_mode = 0;
  bit          hold_reqs = 0;
  bit          fix_rdata_en = 0;
  bit          err_seen = 0;
  logic [31:0] fix_rdata = '0;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_we;
  logic [2:0]  exp_type;
  logic [15:0] log_bits = '0;
  int          log_n = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic tmo, d_if, d_dm;
    @(negedge clk);
    if (owner != 0) bus_ready = ready_never ? 1'b0 : (wait_cnt >= lat);
    else            bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = fix_rdata_en ? fix_rdata : $urandom();
    #1;
    tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo = (owner != 0) && !bus_ready && (wait_cnt == TMO);
`endif
    d_if = (owner == 1) && (bus_ready || tmo);
    d_dm = (owner == 2) && (bus_ready || tmo);
    chk_eq("bus_req", bus_req, owner != 0);
    if (owner != 0) begin
      chk_eq("bus_addr", bus_addr, exp_addr);
      chk_eq("bus_we", bus_we, exp_we);
      chk_eq("bus_type", bus_type, exp_type);
      if (owner == 2) chk_eq("bus_wdata", bus_wdata, exp_wdata);
    end
    chk_eq("if_done", if_done, d_if);
    chk_eq("dm_done", dm_done, d_dm);
    if (d_if) chk_eq("if_rdata", if_rdata, tmo ? 32'h0 : bus_rdata);
    if (d_dm) chk_eq("dm_rdata", dm_rdata, tmo ? 32'h0 : bus_rdata);
    chk_eq("bus_err", bus_err, tmo);
    chk_eq("stall", stall, (if_req && !d_if) || (dm_req && !d_dm));
    if (bus_err) err_seen = 1;
    if (d_if || d_dm) begin
      log_bits = {log_bits[14:0], d_dm};
      log_n++;
    end
    if (owner != 0) begin
      if (d_if || d_dm) owner = 0;
      else wait_cnt++;
    end else if (dm_req && (!if_req || streak < MAXS)) begin
      owner = 2; exp_addr = dm_addr; exp_we = dm_we; exp_wdata = dm_wdata; exp_type = dm_type;
      streak = if_req ? ((streak < 15) ? streak + 1 : 15) : 0;
    end else if (if_req) begin
      owner = 1; exp_addr = if_addr; exp_we = 1'b0; exp_type = 3'b010;
      streak = 0;
    end
    if (owner != 0 && !(d_if || d_dm)) begin
      if (wait_cnt == 0 && bus_req == 1'b0) lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
    end
    @(posedge clk);
    #1;
    if (d_if && !hold_reqs) if_req = 1'b0;
    if (d_dm && !hold_reqs) dm_req = 1'b0;
    if (auto_mode) begin
      if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      else if (owner == 1 && $urandom_range(0, 7) == 0) if_req = 1'b0;
      if (!dm_req) dm_req = ($urandom_range(0, 2) == 0);
      else if (owner == 2 && $urandom_range(0, 7) == 0) dm_req = 1'b0;
      if_addr  = $urandom();
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = $urandom();
      dm_wdata = $urandom();
      dm_type  = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic clear_log();
    log_bits = '0;
    log_n = 0;
  endtask

  initial begin
    int leftover;
    rst = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0;
    dm_wdata = '0; dm_type = '0; bus_ready = 0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_bus_req", bus_req, 0);
    chk_eq("rst_bus_we", bus_we, 0);
    chk_eq("rst_bus_err", bus_err, 0);
    chk_eq("rst_dones", {if_done, dm_done}, 0);
    chk_eq("rst_bus_fields", {bus_addr, bus_wdata[28:0], bus_type}, 0);
    chk_eq("rst_stall", stall, 0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (10) cycle();

    // Single fetch, ready on the second bus cycle.
    lat_fix = 1; fix_rdata_en = 1; fix_rdata = 32'h0010_0093;
    if_addr = 32'h0000_0040; if_req = 1; clear_log();
    for (int i = 0; i < 10 && log_n < 1; i++) cycle();
    chk_eq("fetch_done_cnt", log_n, 1);
    chk_eq("fetch_is_if", log_bits[0], 0);
    repeat (3) cycle();
    chk_eq("fetch_single_pulse", log_n, 1);
    fix_rdata_en = 0;

    // Simultaneous store and fetch: store first.
    lat_fix = 0;
    dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_type = 3'b010;
    if_addr = 32'h44; if_req = 1; dm_req = 1; clear_log();
    for (int i = 0; i < 12 && log_n < 2; i++) cycle();
    chk_eq("simul_cnt", log_n, 2);
    chk_eq("simul_order", log_bits[1:0], 2'b10);

    // Streak limiter with both requesters continuously asserting.
    hold_reqs = 1; if_req = 1; dm_req = 1; dm_we = 0; clear_log();
    for (int i = 0; i < 40 && log_n < 6; i++) cycle();
    chk_eq("streak_cnt", log_n, 6);
    chk_eq("streak_seq", log_bits[5:0], 6'b111101);
    hold_reqs = 0; if_req = 0; dm_req = 0;
    repeat (2) cycle();

    // Asynchronous reset in the middle of a data transaction.
    ready_never = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h200; clear_log();
    repeat (2) cycle();
    chk_eq("rst_pre_owner", owner, 2);
    @(negedge clk); bus_ready = 0; #1; rst = 1'b0; #1;
    chk_eq("arst_bus_req", bus_req, 0);
    chk_eq("arst_dm_done", dm_done, 0);
    chk_eq("arst_bus_addr", bus_addr, 0);
    @(posedge clk); #1;
    dm_req = 0; rst = 1'b1; owner = 0; streak = 0; wait_cnt = 0; ready_never = 0;
    repeat (3) cycle();
    chk_eq("arst_no_done", log_n, 0);

`ifdef ARB_TIMEOUT_EN
    ready_never = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h300; err_seen = 0; clear_log();
    for (int i = 0; i < 20 && log_n < 1; i++) cycle();
    chk_eq("tmo_done", log_n, 1);
    chk_eq("tmo_err_seen", err_seen, 1);
    ready_never = 0; dm_req = 1; err_seen = 0;
    for (int i = 0; i < 10 && log_n < 2; i++) cycle();
    chk_eq("tmo_next_ok", log_n, 2);
    chk_eq("tmo_next_no_err", err_seen, 0);
`endif

    // Randomized traffic.
    lat_fix = -1; auto_mode = 1;
    repeat (1500) cycle();
    auto_mode = 0;
    for (int i = 0; i < 50 && (owner != 0 || if_req || dm_req); i++) cycle();
    leftover = owner + int'(if_req) + int'(dm_req);
    chk_eq("drain", leftover, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(posedge clk) begin
    if (owner != 0 && bus_req === 1'b1 && wait_cnt == 0 && !auto_mode && lat_fix >= 0) lat = lat_fix;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory/MIO bus between the instruction-fetch requester (IF stage) and the data requester (ME stage) of the 5-stage pipelined CPU.
- Serialises one transaction at a time and holds the bus stable until MIO_ready.
- Returns read data and a completion pulse to the owning requester, and drives the pipeline stall.
- Data requests take priority; a streak limiter guarantees that fetch is not starved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch is pending (1..15).
- TIMEOUT_CYC, 255, bus-wait cycles before abort (used only with the optional feature; 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction.
- if_done  out  1  fetch-complete pulse.
- dm_req  in  1  data request; held high until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_type  in  3  access width/sign code (DMType encoding).
- dm_rdata  out  DATA_W  load data.
- dm_done  out  1  data-complete pulse.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_type  out  3  bus DMType.
- bus_rdata  in  DATA_W  bus read data.
- bus_ready  in  1  MIO_ready; transaction completes in the cycle it is high while bus_req = 1.
- stall  out  1  pipeline stall request.
- bus_err  out  1  timeout abort pulse (optional feature only; tied 0 otherwise).

Behaviour:
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- Reset (rst = 0, async): state IDLE. bus_req, bus_we, bus_err, if_done, dm_done = 0. bus_addr, bus_wdata, bus_type, streak counter = 0. Reset mid-transaction abandons it silently; no done pulse.
- IDLE, arbitration at the clock edge:
  - dm_req = 1 and (if_req = 0 or streak < MAX_DM_STREAK) -> DM_BUSY; streak increments (saturating) if if_req = 1, else clears.
  - Else if_req = 1 -> IF_BUSY; streak clears.
  - Else stay IDLE.
- On grant, the winner's address, wdata, we and type are registered onto the bus outputs, and bus_req = 1 from the next cycle.
- bus_we is forced 0 in IF_BUSY, with bus_type = 3'b010 (word).
- Bus outputs stay constant for the whole BUSY state regardless of requester input changes.
- BUSY completion: bus_ready = 1 -> owner's done = 1 in the same cycle (combinational), and owner's rdata = bus_rdata (pass-through). The FSM returns to IDLE at the next edge with bus_req = 0. Minimum occupancy is 2 cycles per transaction; the next grant is in the following IDLE cycle.
- bus_ready while IDLE is ignored.
- The non-owner's done stays 0. if_rdata and dm_rdata outside their done cycle are don't-care but driven from bus_rdata.
- A requester that deasserts req mid-transaction does not abort it; the transaction completes and done still pulses.
- stall = (if_req & ~if_done) | (dm_req & ~dm_done).
- Simultaneous if_req and dm_req with streak < MAX: data wins.
- Simultaneous requests with streak == MAX: fetch wins and the streak clears.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle with bus_ready = 0.
  - When the counter reaches TIMEOUT_CYC without bus_ready: bus_err pulses 1 for one cycle, the owner's done pulses with rdata = 0, and the FSM returns to IDLE.
  - bus_ready in the same cycle the counter reaches TIMEOUT_CYC means normal completion, with no error.
- Undefined: no counter; the FSM waits indefinitely; bus_err is tied 0.

Test Plan:
- Reset is released with both reqs low -> bus_req = 0 and stall = 0 for 10 cycles.
- if_req = 1, if_addr = 0x0000_0040, bus_ready 1 on the 2nd bus cycle with bus_rdata = 0x0010_0093 -> bus_addr = 0x40, bus_we = 0; if_done pulses once with if_rdata = 0x0010_0093; stall is high until the done cycle.
- if_req and dm_req rise together; dm_we = 1, dm_addr = 0x100, dm_wdata = 0xDEAD_BEEF, dm_type = 3'b010 -> the data store is granted first (bus_we = 1, bus_wdata = 0xDEADBEEF), then fetch. No overlap of bus_req between them.
- dm_req held high continuously, if_req high, MAX_DM_STREAK = 4, bus_ready = 1 every BUSY cycle -> grants D, D, D, D, I, D, ...
- rst asserted low during DM_BUSY -> bus_req drops immediately (asynchronously); no dm_done pulse; IDLE after release.
- ARB_TIMEOUT_EN, TIMEOUT_CYC = 8, bus_ready held 0 -> bus_err and dm_done pulse together after 8 wait cycles; dm_rdata = 0; the next request is served normally.
